// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/BTB slice.
// Holds the default widths, the reset PC, the 2-bit direction-counter
// encoding and its saturating update helpers.
package riscv_pkg;

  localparam int unsigned XLEN_DEF     = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  // Direction counter: MSB set means "predict taken".
  typedef enum logic [1:0] {
    CTR_SNT = 2'd0,
    CTR_WNT = 2'd1,
    CTR_WT  = 2'd2,
    CTR_ST  = 2'd3
  } ctr_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == CTR_ST) ? CTR_ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/fetch_btb_if.sv
// Fetch-stage bundle between the fetch unit and the rest of the pipeline.
//   StallF                     : hazard unit -> fetch, hold PC
//   PCF/PCPlus4F               : fetch -> imem / pipeline
//   PredTakenF/PredTargetF     : fetch prediction for PCF
//   UpdateE/PCE/TakenE/TargetE : Execute resolution of a branch/jump
//   PredTakenE/PredTargetE     : prediction delayed to Execute
//   MispredictE                : fetch -> hazard unit redirect/flush
// master = pipeline side, slave = fetch unit.
interface fetch_btb_if import riscv_pkg::*; #(
  parameter int unsigned XLEN = XLEN_DEF
);
  logic            StallF;
  logic [XLEN-1:0] PCF;
  logic [XLEN-1:0] PCPlus4F;
  logic            PredTakenF;
  logic [XLEN-1:0] PredTargetF;
  logic            UpdateE;
  logic [XLEN-1:0] PCE;
  logic            TakenE;
  logic [XLEN-1:0] TargetE;
  logic            PredTakenE;
  logic [XLEN-1:0] PredTargetE;
  logic            MispredictE;

  modport master (
    output StallF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    input  PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
  );

  modport slave (
    input  StallF, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    output PCF, PCPlus4F, PredTakenF, PredTargetF, MispredictE
  );
endinterface

// File: rtl/fetch_btb_btb.sv
// Direct-mapped branch target buffer storage.
//   clk, rst_n        : clock, async active-low reset (clears valid only)
//   rd_wa_i           : fetch lookup word address (PC[XLEN-1:2])
//   rd_hit_o          : valid && tag match
//   rd_pred_o         : direction counter MSB of the looked-up entry
//   rd_target_o       : stored target of the looked-up entry
//   up_wa_i           : training lookup word address (PCE[XLEN-1:2])
//   up_hit_o/up_ctr_o/up_target_o : contents seen by training
//   wr_en_i/wr_wa_i/wr_target_i/wr_ctr_i : synchronous write port
// Writes land at the clock edge, so same-cycle reads see old contents.
module btb import riscv_pkg::*; #(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned ENTRIES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-3:0] rd_wa_i,
  output logic            rd_hit_o,
  output logic            rd_pred_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic [XLEN-3:0] up_wa_i,
  output logic            up_hit_o,
  output ctr_t            up_ctr_o,
  output logic [XLEN-1:0] up_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-3:0] wr_wa_i,
  input  logic [XLEN-1:0] wr_target_i,
  input  ctr_t            wr_ctr_i
);
  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned TW = XLEN - 2 - IW;

  logic [ENTRIES-1:0] valid_q;
  logic [TW-1:0]      tag_q    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  ctr_t               ctr_q    [ENTRIES];

  logic [IW-1:0] rd_idx, up_idx, wr_idx;
  logic [TW-1:0] rd_tag, up_tag, wr_tag;

  always_comb begin
    rd_idx = rd_wa_i[IW-1:0];
    rd_tag = rd_wa_i[XLEN-3:IW];
    up_idx = up_wa_i[IW-1:0];
    up_tag = up_wa_i[XLEN-3:IW];
    wr_idx = wr_wa_i[IW-1:0];
    wr_tag = wr_wa_i[XLEN-3:IW];
  end

  always_comb begin
    rd_hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    rd_pred_o   = ctr_q[rd_idx][1];
    rd_target_o = target_q[rd_idx];
    up_hit_o    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_ctr_o    = ctr_q[up_idx];
    up_target_o = target_q[up_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
      ctr_q[wr_idx]    <= wr_ctr_i;
    end
  end

endmodule

// File: rtl/fetch_btb.sv
// Fetch stage with BTB-based next-PC prediction.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : fetch_btb_if.slave (PC/prediction out, Execute resolution in,
//           MispredictE out to the hazard unit)
// Next PC priority: mispredict redirect > stall > predicted target > PC+4.
module fetch_btb import riscv_pkg::*; #(
  parameter int unsigned     XLEN        = XLEN_DEF,
  parameter int unsigned     BTB_ENTRIES = 16,
  parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEF)
) (
  input  logic       clk,
  input  logic       reset,
  fetch_btb_if.slave bus
);
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] redirect_pc;
  logic            mispredict;

  logic            f_hit, f_pred;
  logic [XLEN-1:0] f_target;
  logic            u_hit;
  ctr_t            u_ctr;
  logic [XLEN-1:0] u_target;

  logic            wr_en;
  logic [XLEN-1:0] wr_target;
  ctr_t            wr_ctr;

  btb #(
    .XLEN    (XLEN),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk         (clk),
    .rst_n       (reset),
    .rd_wa_i     (pc_q[XLEN-1:2]),
    .rd_hit_o    (f_hit),
    .rd_pred_o   (f_pred),
    .rd_target_o (f_target),
    .up_wa_i     (bus.PCE[XLEN-1:2]),
    .up_hit_o    (u_hit),
    .up_ctr_o    (u_ctr),
    .up_target_o (u_target),
    .wr_en_i     (wr_en),
    .wr_wa_i     (bus.PCE[XLEN-1:2]),
    .wr_target_i (wr_target),
    .wr_ctr_i    (wr_ctr)
  );

  always_comb begin
    pc_plus4        = pc_q + XLEN'(4);
    bus.PCF         = pc_q;
    bus.PCPlus4F    = pc_plus4;
    bus.PredTakenF  = f_hit && f_pred;
    bus.PredTargetF = f_hit ? f_target : pc_plus4;
  end

  always_comb begin
    mispredict = bus.UpdateE &&
                 ((bus.TakenE != bus.PredTakenE) ||
                  (bus.TakenE && (bus.TargetE != bus.PredTargetE)));
    redirect_pc     = bus.TakenE ? bus.TargetE : (bus.PCE + XLEN'(4));
    bus.MispredictE = mispredict;
  end

  always_comb begin
    pc_d = pc_plus4;
    if (mispredict) begin
      pc_d = redirect_pc;
    end else if (bus.StallF) begin
      pc_d = pc_q;
    end else if (bus.PredTakenF) begin
      pc_d = bus.PredTargetF;
    end
  end

  // Training: a hit rewrites the whole entry (tag unchanged), so the
  // not-taken case writes back the existing target.
  always_comb begin
    wr_en     = 1'b0;
    wr_target = bus.TargetE;
    wr_ctr    = CTR_WT;
    if (bus.UpdateE) begin
      if (u_hit) begin
        wr_en = 1'b1;
        if (bus.TakenE) begin
          wr_ctr = ctr_inc(u_ctr);
        end else begin
          wr_ctr    = ctr_dec(u_ctr);
          wr_target = u_target;
        end
      end else if (bus.TakenE) begin
        wr_en = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
